uart_line_rx: RTL and testbench

//  Synthesizable, parametrised UART line receiver for the co-sim testbench and for on-chip debug capture.

---
 rtl/uart_line_rx.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_line_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_rx.sv
// UART line receiver: synchronised sampling FSM with parity/framing/break detection,
// feeding a show-ahead FIFO whose entries carry end-of-line and error tags.
module uart_line_rx #(
    parameter int         BIT_RATE     = 9600,
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         PAYLOAD_BITS = 8,
    parameter int         PARITY       = 0,
    parameter int         STOP_BITS    = 1,
    parameter int         DEPTH        = 16,
    parameter logic [7:0] EOL_CHAR     = 8'h0a
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         uart_rxd,
    input  logic                         uart_rx_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic                         out_last,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   lines_pending,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic                         break_det
);

    localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int LPW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     DATA_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LPW-1:0] FULL_CNT  = LPW'(DEPTH);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_line_rx: CLK_HZ/BIT_RATE must be >= 4");
        end
        if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_payload
            $error("uart_line_rx: PAYLOAD_BITS must be 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_line_rx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_line_rx: STOP_BITS must be 1 or 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_line_rx: DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    // ---------------- input synchroniser ----------------
    // [0] first stage, [1] rxd_s, [2] previous rxd_s for edge detection
    logic [2:0] sync_q, sync_d;
    logic       rxd_s, rxd_fall;

    always_comb begin
        sync_d   = {sync_q[1:0], uart_rxd};
        rxd_s    = sync_q[1];
        rxd_fall = sync_q[2] & ~sync_q[1];
    end

    // ---------------- receive FSM ----------------
    state_t                  state_q, state_d;
    logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    break_q, break_d;
    logic                    bit_tick, ferr_now, push;
    logic [7:0]              data_ext;
    rx_entry_t               push_entry;

    always_comb begin
        data_ext                     = '0;
        data_ext[PAYLOAD_BITS-1:0]   = data_q;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        break_d   = 1'b0;
        push      = 1'b0;
        bit_tick  = (clk_cnt_q == BIT_LAST);
        ferr_now  = ferr_q | ~rxd_s;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (uart_rx_en && rxd_fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    state_d   = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    data_d    = {rxd_s, data_q[PAYLOAD_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == 0) ? S_STOP : S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    // XOR of data and parity bit is 1 for a correct odd-parity frame
                    perr_d    = (^data_q ^ rxd_s) ^ (PARITY == 1);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    ferr_d    = ferr_now;
                    if (bit_cnt_q == STOP_LAST) begin
                        if (data_q == '0 && ferr_now) begin
                            break_d = 1'b1;
                            state_d = S_BREAK;
                        end else begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_d = '0;
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disabling the receiver abandons any frame in flight without side effects.
        if (state_q != S_IDLE && !uart_rx_en) begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            push      = 1'b0;
            break_d   = 1'b0;
        end
    end

    always_comb begin
        push_entry.err  = perr_q | ferr_now;
        push_entry.data = data_ext;
        push_entry.last = (data_ext == EOL_CHAR) && !push_entry.err;
    end

    // ---------------- FIFO ----------------
    rx_entry_t      mem_q [DEPTH];
    rx_entry_t      mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LPW-1:0] count_q, count_d;
    logic [LPW-1:0] lines_q, lines_d;
    logic           overflow_q, overflow_d;
    logic           full, push_ok, pop;
    rx_entry_t      head;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        full    = (count_q == FULL_CNT);
        push_ok = push && !full;
        pop     = (count_q != '0) && out_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lines_d  = lines_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            count_d         = count_d + LPW'(1);
            if (push_entry.last) begin
                lines_d = lines_d + LPW'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_d - LPW'(1);
            if (head.last) begin
                lines_d = lines_d - LPW'(1);
            end
        end

        // set beats clear when both land in the same cycle
        overflow_d = overflow_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (push && full) begin
            overflow_d = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= 3'b111;
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            break_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lines_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            break_q    <= break_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lines_q    <= lines_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        out_valid     = (count_q != '0);
        out_data      = out_valid ? head.data : 8'h00;
        out_last      = out_valid & head.last;
        out_err       = out_valid & head.err;
        lines_pending = lines_q;
        overflow      = overflow_q;
        break_det     = break_q;
    end

endmodule

// File: tb/tb_uart_line_rx.sv
// Scoreboard bench for uart_line_rx: 8N1 instance for most scenarios, 8E1 instance for parity.
`timescale 1ns/1ps
module tb_uart_line_rx;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1, en = 1'b1, out_ready = 1'b1, clear_overflow = 1'b0;
    logic       out_valid, out_last, out_err, overflow, break_det;
    logic [7:0] out_data;
    logic [2:0] lines_pending;

    logic       rxd_p = 1'b1, en_p = 1'b1, out_ready_p = 1'b1, clear_overflow_p = 1'b0;
    logic       out_valid_p, out_last_p, out_err_p, overflow_p, break_det_p;
    logic [7:0] out_data_p;
    logic [2:0] lines_pending_p;

    int         n_cmp = 0, n_bad = 0, brk_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_p[$];

    always #5 clk = ~clk;

    uart_line_rx #(
        .BIT_RATE(1_000_000), .CLK_HZ(16_000_000), .PAYLOAD_BITS(8),
        .PARITY(0), .STOP_BITS(1), .DEPTH(4), .EOL_CHAR(8'h0a)
    ) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd), .uart_rx_en(en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_err(out_err), .lines_pending(lines_pending),
        .overflow(overflow), .clear_overflow(clear_overflow), .break_det(break_det)
    );

    uart_line_rx #(
        .BIT_RATE(1_000_000), .CLK_HZ(16_000_000), .PAYLOAD_BITS(8),
        .PARITY(2), .STOP_BITS(1), .DEPTH(4), .EOL_CHAR(8'h0a)
    ) dut_p (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_p), .uart_rx_en(en_p),
        .out_valid(out_valid_p), .out_ready(out_ready_p), .out_data(out_data_p),
        .out_last(out_last_p), .out_err(out_err_p), .lines_pending(lines_pending_p),
        .overflow(overflow_p), .clear_overflow(clear_overflow_p), .break_det(break_det_p)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // output monitors: compare every accepted beat with the scoreboard
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 32'(exp_q.size()), 1);
            else chk("beat", {22'd0, out_err, out_last, out_data}, {22'd0, exp_q.pop_front()});
        end
        if (resetn && out_valid_p && out_ready_p) begin
            if (exp_p.size() == 0) chk("unexpected_beat_p", 32'(exp_p.size()), 1);
            else chk("beat_p", {22'd0, out_err_p, out_last_p, out_data_p}, {22'd0, exp_p.pop_front()});
        end
        if (break_det) brk_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit which, input logic v, input int n);
        if (which) rxd_p = v;
        else rxd = v;
        wait_clks(n);
    endtask

    // start, 8 data LSB first, optional even parity, one stop bit, one idle bit time
    task automatic send_frame(input bit which, input logic [7:0] b, input bit par_en,
                              input bit par_flip, input logic stop_v, input int drop_at);
        drive_bit(which, 1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == drop_at) en = 1'b0;
            drive_bit(which, b[i], 16);
        end
        if (par_en) drive_bit(which, (^b) ^ par_flip, 16);
        drive_bit(which, stop_v, 16);
        drive_bit(which, 1'b1, 16);
    endtask

    initial begin
        int b0;
        wait_clks(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_lines", lines_pending, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_break", break_det, 0);
        resetn = 1'b1;
        wait_clks(32);

        // 1: a short line
        exp_q.push_back({2'b00, 8'h48}); send_frame(0, 8'h48, 0, 0, 1'b1, -1);
        exp_q.push_back({2'b00, 8'h69}); send_frame(0, 8'h69, 0, 0, 1'b1, -1);
        chk("t1_lines_before_eol", lines_pending, 0);
        exp_q.push_back({2'b01, 8'h0a});
        fork
            send_frame(0, 8'h0a, 0, 0, 1'b1, -1);
            begin
                int n;
                n = 0;
                while (!(out_valid && out_last) && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("t1_eol_seen", 32'(n < 400), 1);
                chk("t1_lines_one", lines_pending, 1);
                @(negedge clk);
                chk("t1_lines_zero", lines_pending, 0);
            end
        join

        // 2: even parity, bad then good
        exp_p.push_back({2'b10, 8'h0a}); send_frame(1, 8'h0a, 1, 1, 1'b1, -1);
        chk("t2_lines", lines_pending_p, 0);
        exp_p.push_back({2'b00, 8'h07}); send_frame(1, 8'h07, 1, 0, 1'b1, -1);
        exp_p.push_back({2'b01, 8'h0a}); send_frame(1, 8'h0a, 1, 0, 1'b1, -1);

        // 3: framing error, then a break, then recovery
        exp_q.push_back({2'b10, 8'h55}); send_frame(0, 8'h55, 0, 0, 1'b0, -1);
        b0 = brk_cnt;
        drive_bit(0, 1'b0, 480);
        drive_bit(0, 1'b1, 32);
        chk("t3_break_pulses", 32'(brk_cnt - b0), 1);
        chk("t3_no_beat", out_valid, 0);
        exp_q.push_back({2'b00, 8'h41}); send_frame(0, 8'h41, 0, 0, 1'b1, -1);

        // 4: overflow with a stalled consumer
        out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            if (v <= 4) exp_q.push_back({2'b00, 8'(v)});
            send_frame(0, 8'(v), 0, 0, 1'b1, -1);
            if (v == 1) chk("t4_head_first", out_data, 1);
        end
        chk("t4_ovf", overflow, 1);
        chk("t4_valid", out_valid, 1);
        chk("t4_head_held", out_data, 1);
        out_ready = 1'b1;
        wait_clks(8);
        chk("t4_drained", 32'(exp_q.size()), 0);
        chk("t4_empty", out_valid, 0);
        chk("t4_ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        wait_clks(1);
        clear_overflow = 1'b0;
        chk("t4_ovf_clear", overflow, 0);

        // 5: glitch and aborted frame, then a clean byte
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 48);
        chk("t5_glitch", out_valid, 0);
        send_frame(0, 8'h33, 0, 0, 1'b1, 3);
        en = 1'b1;
        wait_clks(16);
        chk("t5_abort", out_valid, 0);
        exp_q.push_back({2'b00, 8'h34}); send_frame(0, 8'h34, 0, 0, 1'b1, -1);

        // 6: reset with FIFO contents and a frame in flight
        out_ready = 1'b0;
        send_frame(0, 8'h10, 0, 0, 1'b1, -1);
        send_frame(0, 8'h0a, 0, 0, 1'b1, -1);
        send_frame(0, 8'h20, 0, 0, 1'b1, -1);
        chk("t6_valid", out_valid, 1);
        chk("t6_lines", lines_pending, 1);
        drive_bit(0, 1'b0, 16);
        drive_bit(0, 1'b1, 16);
        drive_bit(0, 1'b0, 8);
        resetn = 1'b0;
        rxd = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_lines", lines_pending, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_data", out_data, 0);
        wait_clks(4);
        resetn = 1'b1;
        out_ready = 1'b1;
        wait_clks(32);
        exp_q.push_back({2'b00, 8'h5a}); send_frame(0, 8'h5a, 0, 0, 1'b1, -1);
        wait_clks(16);

        chk("final_scoreboard", 32'(exp_q.size() + exp_p.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
